// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control sequencer: FSM states, opcodes,
// ALU operations and datapath select values.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [4:0] OP_R    = 5'h00;
    localparam logic [4:0] OP_ADDI = 5'h01;
    localparam logic [4:0] OP_ANDI = 5'h02;
    localparam logic [4:0] OP_ORI  = 5'h03;
    localparam logic [4:0] OP_LW   = 5'h04;
    localparam logic [4:0] OP_SW   = 5'h05;
    localparam logic [4:0] OP_BEQ  = 5'h06;
    localparam logic [4:0] OP_JMP  = 5'h07;
    localparam logic [4:0] OP_HALT = 5'h1F;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_IMM  = 2'd1;
    localparam logic [1:0] ALU_B_FOUR = 2'd2;

endpackage

// File: rtl/mc_control_decode.sv
// Combinational opcode -> control-class decode for mc_control.
// Optional feature macro: IMM_ZEXT_EN (zero-extend ANDI/ORI immediates).
module mc_decode
    import mc_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [3:0] funct,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_halt,
    output logic       legal
);

    logic logical_imm;

    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_b   = ALU_B_RS2;
        logical_imm = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_branch   = 1'b0;
        is_jump     = 1'b0;
        is_halt     = 1'b0;
        legal       = 1'b1;
        case (opcode)
            OP_R:    alu_op = funct;
            OP_ADDI: alu_src_b = ALU_B_IMM;
            OP_ANDI: begin
                alu_src_b   = ALU_B_IMM;
                alu_op      = ALU_AND;
                logical_imm = 1'b1;
            end
            OP_ORI: begin
                alu_src_b   = ALU_B_IMM;
                alu_op      = ALU_OR;
                logical_imm = 1'b1;
            end
            OP_LW: begin
                alu_src_b = ALU_B_IMM;
                is_load   = 1'b1;
            end
            OP_SW: begin
                alu_src_b = ALU_B_IMM;
                is_store  = 1'b1;
            end
            OP_BEQ: begin
                alu_op    = ALU_SUB;
                is_branch = 1'b1;
            end
            OP_JMP:  is_jump = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Without the feature every immediate is sign-extended.
`ifdef IMM_ZEXT_EN
    assign ext_zero = logical_imm;
`else
    logic unused_logical_imm;
    assign unused_logical_imm = logical_imm;
    assign ext_zero           = 1'b0;
`endif

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/write-back FSM
// driving all datapath selects. Optional feature macro: IMM_ZEXT_EN.
module mc_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic        ext_zero,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        halted,
    output logic        illegal
);

    state_t     state;
    state_t     state_next;
    logic [4:0] op_q;
    logic [3:0] funct_q;
    logic [4:0] dec_opcode;
    logic [3:0] dec_funct;

    logic [3:0] dec_alu_op;
    logic [1:0] dec_alu_src_b;
    logic       dec_ext_zero;
    logic       dec_load;
    logic       dec_store;
    logic       dec_branch;
    logic       dec_jump;
    logic       dec_halt;
    logic       dec_legal;

    logic       unused_instr;
    assign unused_instr = ^instr[26:4];

    // The opcode register only becomes valid after DECODE, so decode the IR directly there.
    assign dec_opcode = (state == ST_DECODE) ? instr[31:27] : op_q;
    assign dec_funct  = (state == ST_DECODE) ? instr[3:0]   : funct_q;

    mc_decode u_decode (
        .opcode    (dec_opcode),
        .funct     (dec_funct),
        .alu_op    (dec_alu_op),
        .alu_src_b (dec_alu_src_b),
        .ext_zero  (dec_ext_zero),
        .is_load   (dec_load),
        .is_store  (dec_store),
        .is_branch (dec_branch),
        .is_jump   (dec_jump),
        .is_halt   (dec_halt),
        .legal     (dec_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_BOOT;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                op_q    <= instr[31:27];
                funct_q <= instr[3:0];
            end
        end
    end

    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_SEQ;
        alu_src_b    = ALU_B_RS2;
        alu_op       = ALU_ADD;
        ext_zero     = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 1'b0;
        halted       = 1'b0;
        illegal      = 1'b0;
        case (state)
            ST_BOOT: state_next = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    pc_src     = PC_SRC_SEQ;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ext_zero = dec_ext_zero;
                if (dec_halt) begin
                    state_next = ST_HALT;
                end else if (!dec_legal) begin
                    illegal    = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ext_zero  = dec_ext_zero;
                alu_op    = dec_alu_op;
                alu_src_b = dec_alu_src_b;
                if (dec_branch) begin
                    pc_we      = alu_zero;
                    pc_src     = PC_SRC_BRANCH;
                    state_next = ST_FETCH;
                end else if (dec_jump) begin
                    pc_we      = 1'b1;
                    pc_src     = PC_SRC_JUMP;
                    state_next = ST_FETCH;
                end else if (dec_load || dec_store) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                ext_zero     = dec_ext_zero;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = dec_store;
                if (mem_ready) begin
                    state_next = dec_store ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                ext_zero   = dec_ext_zero;
                rf_we      = 1'b1;
                wb_sel     = dec_load;
                state_next = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_next = ST_BOOT;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: a per-instruction phase model expands
// each instruction into the expected cycle-by-cycle output trace.
module tb_mc_control;
    import mc_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       ext_zero;
        logic       rf_we;
        logic       wb_sel;
        logic       halted;
        logic       illegal;
    } outs_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        mem_ready;
        logic        alu_zero;
        outs_t       exp;
    } step_t;

`ifdef IMM_ZEXT_EN
    localparam bit ZEXT = 1'b1;
`else
    localparam bit ZEXT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0]  pc_src, alu_src_b;
    logic [3:0]  alu_op;
    logic        ext_zero, rf_we, wb_sel, halted, illegal;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    step_t step_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    mc_control dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .alu_zero     (alu_zero),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .ext_zero     (ext_zero),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .illegal      (illegal)
    );

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t sample_outs();
        outs_t o;
        o.mem_req      = mem_req;
        o.mem_we       = mem_we;
        o.mem_addr_sel = mem_addr_sel;
        o.ir_we        = ir_we;
        o.pc_we        = pc_we;
        o.pc_src       = pc_src;
        o.alu_src_b    = alu_src_b;
        o.alu_op       = alu_op;
        o.ext_zero     = ext_zero;
        o.rf_we        = rf_we;
        o.wb_sel       = wb_sel;
        o.halted       = halted;
        o.illegal      = illegal;
        return o;
    endfunction

    task automatic push(input string nm, input logic [31:0] ins, input logic rdy,
                        input logic z, input outs_t e);
        step_t s;
        s.instr     = ins;
        s.mem_ready = rdy;
        s.alu_zero  = z;
        s.exp       = e;
        step_q.push_back(s);
        name_q.push_back(nm);
    endtask

    // Expand one instruction into its phases; mem_ready/alu_zero are random where they must not matter.
    task automatic add_instr(input logic [4:0] op, input logic [3:0] fn, input int fwaits,
                             input int mwaits, input logic z);
        logic [31:0] ins;
        outs_t       e;
        logic        ez;
        logic        defined;
        ins        = $urandom;
        ins[31:27] = op;
        ins[3:0]   = fn;
        ez      = ZEXT && (op == OP_ANDI || op == OP_ORI);
        defined = (op <= OP_JMP) || (op == OP_HALT);
        for (int i = 0; i < fwaits; i++) begin
            e = '0; e.mem_req = 1'b1;
            push("fetch_wait", ins, 1'b0, rbit(), e);
        end
        e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.pc_src = 2'd0;
        push("fetch", ins, 1'b1, rbit(), e);
        e = '0; e.ext_zero = ez; e.illegal = !defined;
        push("decode", ins, rbit(), rbit(), e);
        if (!defined || op == OP_HALT) return;
        e = '0; e.ext_zero = ez;
        case (op)
            OP_R:                  e.alu_op = fn;
            OP_ADDI, OP_LW, OP_SW: begin e.alu_src_b = 2'd1; e.alu_op = ALU_ADD; end
            OP_ANDI:               begin e.alu_src_b = 2'd1; e.alu_op = ALU_AND; end
            OP_ORI:                begin e.alu_src_b = 2'd1; e.alu_op = ALU_OR;  end
            OP_BEQ:                begin e.alu_op = ALU_SUB; e.pc_we = z; e.pc_src = 2'd1; end
            default:               begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
        endcase
        push("exec", ins, rbit(), z, e);
        if (op == OP_BEQ || op == OP_JMP) return;
        if (op == OP_LW || op == OP_SW) begin
            for (int i = 0; i < mwaits; i++) begin
                e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = (op == OP_SW);
                push("mem_wait", ins, 1'b0, rbit(), e);
            end
            e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = (op == OP_SW);
            push("mem", ins, 1'b1, rbit(), e);
            if (op == OP_SW) return;
        end
        e = '0; e.ext_zero = ez; e.rf_we = 1'b1; e.wb_sel = (op == OP_LW);
        push("wb", ins, rbit(), rbit(), e);
    endtask

    task automatic add_halt_cycles(input int n);
        outs_t e;
        for (int i = 0; i < n; i++) begin
            e = '0; e.halted = 1'b1;
            push("halt", $urandom, rbit(), rbit(), e);
        end
    endtask

    // Called at posedge+1; leaves the DUT in BOOT with the BOOT cycle queued.
    task automatic do_reset();
        rst       = 1'b1;
        instr     = $urandom;
        mem_ready = rbit();
        @(posedge clk); #1;
        rst = 1'b0;
        push("boot", $urandom, rbit(), rbit(), '0);
    endtask

    task automatic run_step(input step_t s, output outs_t got);
        instr     = s.instr;
        mem_ready = s.mem_ready;
        alu_zero  = s.alu_zero;
        @(negedge clk);
        got = sample_outs();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset();
        outs_t got;
        step_t s;
        string nm;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = $urandom; mem_ready = rbit(); alu_zero = rbit();
            @(negedge clk);
            checks++;
            if (sample_outs() !== '0) begin
                errors++;
                $display("[TB] FAIL reset_hold got %b exp %b", sample_outs(), outs_t'('0));
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        push("boot", $urandom, rbit(), rbit(), '0);
        add_instr(OP_ADDI, 4'($urandom), 0, 0, rbit());
        while (step_q.size() > 0) begin
            s = step_q.pop_front(); nm = name_q.pop_front();
            run_step(s, got);
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL reset_addi.%s cyc %0d got %b exp %b", nm, cyc, got, s.exp);
            end
        end
    endtask

    task automatic test_fetch_wait();
        outs_t got;
        step_t s;
        string nm;
        do_reset();
        add_instr(OP_R, 4'h5, 3, 0, rbit());
        add_instr(OP_ADDI, 4'($urandom), 1, 0, rbit());
        while (step_q.size() > 0) begin
            s = step_q.pop_front(); nm = name_q.pop_front();
            run_step(s, got);
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL fetch_wait.%s cyc %0d got %b exp %b", nm, cyc, got, s.exp);
            end
        end
    endtask

    task automatic test_load_store();
        outs_t got;
        step_t s;
        string nm;
        do_reset();
        add_instr(OP_LW, 4'($urandom), 0, 0, rbit());
        add_instr(OP_SW, 4'($urandom), 0, 0, rbit());
        add_instr(OP_LW, 4'($urandom), 1, 2, rbit());
        add_instr(OP_SW, 4'($urandom), 2, 3, rbit());
        while (step_q.size() > 0) begin
            s = step_q.pop_front(); nm = name_q.pop_front();
            run_step(s, got);
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL load_store.%s cyc %0d got %b exp %b", nm, cyc, got, s.exp);
            end
        end
    endtask

    task automatic test_branch_jump();
        outs_t got;
        step_t s;
        string nm;
        do_reset();
        add_instr(OP_BEQ, 4'($urandom), 0, 0, 1'b1);
        add_instr(OP_BEQ, 4'($urandom), 0, 0, 1'b0);
        add_instr(OP_JMP, 4'($urandom), 0, 0, rbit());
        add_instr(OP_BEQ, 4'($urandom), 2, 0, 1'b1);
        while (step_q.size() > 0) begin
            s = step_q.pop_front(); nm = name_q.pop_front();
            run_step(s, got);
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL branch_jump.%s cyc %0d got %b exp %b", nm, cyc, got, s.exp);
            end
        end
    endtask

    task automatic test_logical_imm();
        outs_t got;
        step_t s;
        string nm;
        do_reset();
        add_instr(OP_ORI, 4'($urandom), 0, 0, rbit());
        add_instr(OP_ANDI, 4'($urandom), 1, 0, rbit());
        add_instr(OP_ADDI, 4'($urandom), 0, 0, rbit());
        while (step_q.size() > 0) begin
            s = step_q.pop_front(); nm = name_q.pop_front();
            run_step(s, got);
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL logical_imm.%s cyc %0d got %b exp %b", nm, cyc, got, s.exp);
            end
        end
    endtask

    task automatic test_random_program();
        outs_t       got;
        step_t       s;
        string       nm;
        logic [4:0]  op;
        logic [4:0]  legal_ops [8];
        legal_ops = '{OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_JMP};
        do_reset();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(8, 30));
            else                           op = legal_ops[$urandom_range(0, 7)];
            add_instr(op, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), rbit());
        end
        while (step_q.size() > 0) begin
            s = step_q.pop_front(); nm = name_q.pop_front();
            run_step(s, got);
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL random.%s cyc %0d got %b exp %b", nm, cyc, got, s.exp);
            end
        end
    endtask

    task automatic test_illegal_halt();
        outs_t got;
        step_t s;
        string nm;
        do_reset();
        add_instr(5'h10, 4'($urandom), 0, 0, rbit());
        add_instr(OP_HALT, 4'($urandom), 1, 0, rbit());
        add_halt_cycles(6);
        while (step_q.size() > 0) begin
            s = step_q.pop_front(); nm = name_q.pop_front();
            run_step(s, got);
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL illegal_halt.%s cyc %0d got %b exp %b", nm, cyc, got, s.exp);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        outs_t got;
        step_t s;
        string nm;
        do_reset();
        add_instr(OP_LW, 4'($urandom), 0, 3, rbit());
        // BOOT, FETCH, DECODE, EXEC and two MEM wait cycles; the third wait cycle is aborted.
        for (int k = 0; k < 6; k++) begin
            s = step_q.pop_front(); nm = name_q.pop_front();
            run_step(s, got);
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL mid_access.%s cyc %0d got %b exp %b", nm, cyc, got, s.exp);
            end
        end
        step_q.delete();
        name_q.delete();
        mem_ready = 1'b0;
        #2;
        checks++;
        if (mem_req !== 1'b1 || mem_addr_sel !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_access.pre_rst mem_req %b addr_sel %b exp 1 1", mem_req, mem_addr_sel);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sample_outs() !== '0) begin
            errors++;
            $display("[TB] FAIL mid_access.rst_async got %b exp %b", sample_outs(), outs_t'('0));
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (sample_outs() !== '0) begin
                errors++;
                $display("[TB] FAIL mid_access.rst_hold got %b exp %b", sample_outs(), outs_t'('0));
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        push("boot", $urandom, rbit(), rbit(), '0);
        add_instr(OP_R, 4'($urandom), 0, 0, rbit());
        while (step_q.size() > 0) begin
            s = step_q.pop_front(); nm = name_q.pop_front();
            run_step(s, got);
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL mid_access.%s cyc %0d got %b exp %b", nm, cyc, got, s.exp);
            end
        end
    endtask

    initial begin
        $display("[TB] mc_control bench start, zero-extend feature = %0d", ZEXT);
        test_reset();
        test_fetch_wait();
        test_load_store();
        test_branch_jump();
        test_logical_imm();
        test_illegal_halt();
        test_reset_mid_access();
        test_random_program();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog time limit reached got running exp finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control sequencer for the 32-bit processor core. Walks each instruction through fetch, decode, execute, memory and write-back, and drives every datapath select: PC, instruction register, register file, ALU operand and op, and the immediate-extension mode of the 15-bit immediate extender. Sits beside the datapath and talks to the unified memory port through a req/ready handshake.

## Interface
- No parameters. Opcode and ALU-op encodings come from the shared package.
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  32  instruction register contents: opcode [31:27], rd [26:22], rs1 [21:17], rs2 [16:12] (R-type), imm [14:0], funct [3:0]
- mem_ready  in  1  memory completes the pending access this cycle
- alu_zero  in  1  ALU result equals zero
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for mem_req
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load instruction register
- pc_we  out  1  load PC
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- alu_src_b  out  2  0 = rs2, 1 = extended immediate, 2 = constant 4
- alu_op  out  4  ALU operation
- ext_zero  out  1  1 = zero-extend immediate, 0 = sign-extend
- rf_we  out  1  register file write
- wb_sel  out  1  0 = ALU result, 1 = memory data
- halted  out  1  core stopped on HALT
- illegal  out  1  one-cycle pulse on undefined opcode

## Operation
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT. 3-bit encoding.
- BOOT: reset state; every output 0; unconditionally → FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. Stays until mem_ready=1; in that cycle ir_we=1, pc_we=1, pc_src=0 → DECODE.
- DECODE: latch instr[31:27] and funct into an internal opcode register; all strobes 0. HALT opcode → HALT. Undefined opcode → illegal=1, → FETCH (treated as NOP). Otherwise → EXEC.
- EXEC: R-type alu_src_b=0, alu_op=funct; ADDI/LW/SW alu_src_b=1, alu_op=ADD; ANDI/ORI alu_src_b=1, alu_op=AND/OR. BEQ: alu_op=SUB, alu_src_b=0; pc_we=alu_zero, pc_src=1 → FETCH. JMP: pc_we=1, pc_src=2 → FETCH. LW/SW → MEM; ALU ops → WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for SW. Held until mem_ready=1. SW → FETCH, LW → WB.
- WB: rf_we=1; wb_sel=1 for LW, else 0 → FETCH.
- HALT: halted=1, all other outputs 0; exits only via reset.
- Opcodes: R=0x00, ADDI=0x01, ANDI=0x02, ORI=0x03, LW=0x04, SW=0x05, BEQ=0x06, JMP=0x07, HALT=0x1F; all others undefined.
- ext_zero held for the whole instruction from DECODE to return to FETCH; 0 outside.
- All outputs are decoded from the state register and the latched opcode only (Moore), except the mem_ready-qualified strobes in FETCH and alu_zero-qualified pc_we in EXEC.

## Timing
- Reset: asynchronous entry to BOOT; all outputs 0 while rst=1 and in BOOT; first mem_req one cycle after rst falls.
- Zero-wait CPI: R/I-type 4, LW 5, SW 4, BEQ/JMP 3, undefined 2.
- Each wait cycle (mem_ready=0 while requesting) adds one cycle; mem_req, mem_we, mem_addr_sel stable throughout.
- mem_ready while mem_req=0 is ignored.
- mem_req drops the cycle after the accepting mem_ready.
- Reset mid-access: mem_req falls immediately; no ir_we, pc_we or rf_we issued for the aborted instruction.

## Configuration
- IMM_ZEXT_EN defined: ANDI and ORI drive ext_zero=1 (logical immediates zero-extended).
- Not defined: ext_zero tied 0; all immediates sign-extended; ANDI/ORI behave otherwise identically.

## Structure
- Shared package: state enum, opcode constants, ALU-op constants, pc_src and alu_src_b select encodings.
- One sub-module: mc_decode, combinational opcode → control-class decode (alu_op, alu_src_b, ext_zero, is_mem/is_branch/legal), instantiated by the FSM.

## Test plan
- Reset then ADDI, mem_ready always 1 -> mem_req at cycle 1, ir_we at cycle 1, rf_we at cycle 4, alu_src_b=1, ext_zero=0.
- FETCH with mem_ready low 3 cycles -> mem_req high 4 cycles, single ir_we/pc_we pulse on 4th.
- LW then SW -> LW: MEM then WB with wb_sel=1; SW: mem_we=1 in MEM, no rf_we.
- BEQ with alu_zero=1 then 0 -> pc_we with pc_src=1 only in first; both back in FETCH after 3 cycles.
- Opcode 0x10 then 0x1F -> illegal pulse, refetch; then halted=1 and no mem_req until rst.
- ORI with and without IMM_ZEXT_EN -> ext_zero 1 vs 0 during DECODE..WB; rst asserted mid-MEM clears mem_req immediately.
